// File: rtl/mega_mul_iter_pkg.sv
// Shared encodings for the iterative MEGA multiplier.
// Fractional support is controlled by MEGA_MUL_FMUL_EN.
package mega_mul_iter_pkg;

  localparam logic [1:0] MUL_MODE_UU = 2'b00;
  localparam logic [1:0] MUL_MODE_SU = 2'b01;
  localparam logic [1:0] MUL_MODE_SS = 2'b10;
  localparam int MUL_MODE_FRAC = 2;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mega_mul_step.sv
// One shift-add radix step of the iterative multiplier.
// Adds mcand times the low multiplier digit into the upper half.
module mega_mul_step #(
  parameter int WIDTH      = 8,
  parameter int RADIX_BITS = 1
) (
  input  logic [2*WIDTH:0]  acc_i,
  input  logic [WIDTH-1:0]  mcand_i,
  input  logic [WIDTH-1:0]  mplier_i,
  output logic [2*WIDTH:0]  acc_o,
  output logic [WIDTH-1:0]  mplier_o
);

  localparam int SW = WIDTH + RADIX_BITS + 1;

  logic [SW-1:0]                pp;
  logic [SW-1:0]                sum;
  logic [SW+WIDTH-1:0]          wide;

  always_comb begin
    pp = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (mplier_i[i]) begin
        pp = pp + (SW'(mcand_i) << i);
      end
    end
    sum  = SW'(acc_i[2*WIDTH:WIDTH]) + pp;
    wide = {sum, acc_i[WIDTH-1:0]};
    acc_o    = wide[2*WIDTH+RADIX_BITS:RADIX_BITS];
    mplier_o = mplier_i >> RADIX_BITS;
  end

endmodule

// File: rtl/mega_mul_iter.sv
// Iterative sign-magnitude shift-add multiplier for MUL/MULS/MULSU/FMUL*.
// Define MEGA_MUL_FMUL_EN to honour mode[2] (fractional result).
module mega_mul_iter
  import mega_mul_iter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RADIX_BITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [7:0]         sreg_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [7:0]         sreg_out
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;

  mul_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [PW:0]        acc_q;
  logic               neg_q;
  logic [7:0]         sreg_q;
  logic               busy_q;
  logic               done_q;
  logic [PW-1:0]      result_q;
  logic [7:0]         sreg_out_q;

  logic               sa_d;
  logic               sb_d;
  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic               neg_d;
  logic [PW-1:0]      p_d;
  logic [PW-1:0]      res_d;
  logic [7:0]         sreg_d;
  logic [PW:0]        acc_nx;
  logic [WIDTH-1:0]   mplier_nx;

`ifdef MEGA_MUL_FMUL_EN
  logic               frac_q;
`else
  logic               unused_frac;
  assign unused_frac = mode[MUL_MODE_FRAC];
`endif

  mega_mul_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_nx),
    .mplier_o (mplier_nx)
  );

  always_comb begin
    sa_d = (mode[1:0] == MUL_MODE_SU) ||
           (mode[1:0] == MUL_MODE_SS);
    sb_d = (mode[1:0] == MUL_MODE_SS);
    mag_a_d = (sa_d && a[WIDTH-1]) ? -a : a;
    mag_b_d = (sb_d && b[WIDTH-1]) ? -b : b;
    neg_d = (sa_d & a[WIDTH-1]) ^ (sb_d & b[WIDTH-1]);
    p_d = neg_q ? -acc_q[PW-1:0] : acc_q[PW-1:0];
`ifdef MEGA_MUL_FMUL_EN
    res_d = frac_q ? {p_d[PW-2:0], 1'b0} : p_d;
`else
    res_d = p_d;
`endif
    sreg_d = sreg_q;
    sreg_d[FLAG_C] = p_d[PW-1];
    sreg_d[FLAG_Z] = (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      sreg_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      sreg_out_q <= '0;
`ifdef MEGA_MUL_FMUL_EN
      frac_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= mag_a_d;
            mplier_q <= mag_b_d;
            neg_q    <= neg_d;
            sreg_q   <= sreg_in;
            acc_q    <= '0;
            cnt_q    <= CW'(N);
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
`ifdef MEGA_MUL_FMUL_EN
            frac_q   <= mode[MUL_MODE_FRAC];
`endif
          end
        end
        ST_RUN: begin
          acc_q    <= acc_nx;
          mplier_q <= mplier_nx;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          result_q   <= res_d;
          sreg_out_q <= sreg_d;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign sreg_out = sreg_out_q;

endmodule

// File: tb/tb_mega_mul_iter.sv
// Randomised bench for mega_mul_iter at W=8/R=1 and W=16/R=4.
// Expected values come from signed integer arithmetic.
module tb_mega_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [2:0]  mode8, mode16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [7:0]  si8, si16;
  logic        busy8, busy16;
  logic        done8, done16;
  logic [15:0] res8;
  logic [31:0] res16;
  logic [7:0]  so8, so16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mega_mul_iter #(.WIDTH(8), .RADIX_BITS(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8),
    .a(a8), .b(b8), .sreg_in(si8), .busy(busy8),
    .done(done8), .result(res8), .sreg_out(so8)
  );

  mega_mul_iter #(.WIDTH(16), .RADIX_BITS(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16),
    .a(a16), .b(b16), .sreg_in(si16), .busy(busy16),
    .done(done16), .result(res16), .sreg_out(so16)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {sreg_out, result} for operand width w.
  function automatic logic [39:0] ref_mul(input int w,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [2:0] m,
                                          input logic [7:0] s);
    longint va, vb, p, r, mask;
    logic [7:0] so;
    mask = (longint'(1) << (2 * w)) - 1;
    va = longint'(a);
    vb = longint'(b);
    if ((m[1:0] == 2'b01 || m[1:0] == 2'b10) && a[w-1])
      va = va - (longint'(1) << w);
    if (m[1:0] == 2'b10 && b[w-1])
      vb = vb - (longint'(1) << w);
    p = (va * vb) & mask;
    r = p;
`ifdef MEGA_MUL_FMUL_EN
    if (m[2]) r = (p << 1) & mask;
`endif
    so = s;
    so[0] = ((p >> (2 * w - 1)) & 1) != 0;
    so[1] = (r == 0);
    return {so, r[31:0]};
  endfunction

  task automatic launch(input bit big, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] m,
                        input logic [7:0] s);
    if (big) begin
      a16 = a; b16 = b; mode16 = m; si16 = s; start16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; mode8 = m; si8 = s; start8 = 1'b1;
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    start8 = 1'b0;
    start16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom);
    mode8 = 3'($urandom); si8 = 8'($urandom);
    mode16 = 3'($urandom); si16 = 8'($urandom);
    check(big ? "busy16_after_start" : "busy8_after_start",
          64'(big ? busy16 : busy8), 64'd1);
  endtask

  task automatic wait_done(input bit big, input int lat,
                           input logic [39:0] exp, input string tag);
    while (!(big ? done16 : done8) && (cyc - t0) < 40) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_latency"}, 64'(cyc - t0), 64'(lat));
    check({tag, "_busy"}, 64'(big ? busy16 : busy8), 64'd0);
    if (big) begin
      check({tag, "_result"}, 64'(res16), 64'(exp[31:0]));
      check({tag, "_sreg"}, 64'(so16), 64'(exp[39:32]));
    end else begin
      check({tag, "_result"}, 64'(res8), 64'(exp[15:0]));
      check({tag, "_sreg"}, 64'(so8), 64'(exp[39:32]));
    end
  endtask

  task automatic op(input bit big, input logic [15:0] a,
                    input logic [15:0] b, input logic [2:0] m,
                    input logic [7:0] s, input string tag);
    logic [39:0] e;
    e = ref_mul(big ? 16 : 8, a, b, m, s);
    launch(big, a, b, m, s);
    wait_done(big, big ? 5 : 9, e, tag);
  endtask

  initial begin
    logic [39:0] e;
    int ndone;
    rst = 1'b1;
    start8 = 0; start16 = 0;
    mode8 = 0; mode16 = 0;
    a8 = 0; b8 = 0; a16 = 0; b16 = 0;
    si8 = 0; si16 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_res8", 64'(res8), 64'd0);
    check("rst_sreg8", 64'(so8), 64'd0);
    check("rst_res16", 64'(res16), 64'd0);
    check("rst_sreg16", 64'(so16), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op(0, 16'hFF, 16'hFF, 3'b000, 8'hA4, "uu_ff_ff");
    op(0, 16'h80, 16'h80, 3'b010, 8'h00, "ss_80_80");
    op(0, 16'h80, 16'h80, 3'b110, 8'h00, "fss_80_80");
    op(0, 16'hFF, 16'hFF, 3'b001, 8'h5C, "su_ff_ff");
    op(0, 16'h00, 16'h37, 3'b000, 8'hFF, "zero");
    op(0, 16'hC3, 16'h5A, 3'b011, 8'h3C, "mode11_uu");
    op(0, 16'h40, 16'h80, 3'b100, 8'h81, "fuu_wrap");

    // A start during RUN must not disturb the running op.
    e = ref_mul(8, 16'h12, 16'h34, 3'b000, 8'h10);
    launch(0, 16'h12, 16'h34, 3'b000, 8'h10);
    repeat (2) @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; mode8 = 3'b010;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done(0, 9, e, "ignored_start");

    // Start on the done cycle is accepted.
    op(0, 16'h9D, 16'hE7, 3'b010, 8'h77, "back_to_back");

    for (int i = 0; i < 12; i++) begin
      op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
         3'($urandom), 8'($urandom), "rand8");
    end

    launch(0, 16'h7B, 16'h6D, 3'b000, 8'hEE);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", 64'(busy8), 64'd0);
    check("midrst_done", 64'(done8), 64'd0);
    check("midrst_res", 64'(res8), 64'd0);
    check("midrst_sreg", 64'(so8), 64'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done8) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);

    op(1, 16'h8000, 16'h8000, 3'b010, 8'h00, "w16_ss_min");
    op(1, 16'hFFFF, 16'hFFFF, 3'b000, 8'hFF, "w16_uu_max");
    op(1, 16'h8000, 16'h8000, 3'b110, 8'h12, "w16_fss_min");
    for (int i = 0; i < 40; i++) begin
      op(1, 16'($urandom), 16'($urandom), 3'($urandom),
         8'($urandom), "rand16");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
